pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Generic, parametrised pipeline stage register for the 5-stage MIPS CPU. It replaces the per-stage D/E/M/W registers with one block. The payload is a packed bundle of NUM_FIELDS fields of FIELD_W bits each, for example IR, PC4, RS, RT and D32 at the E stage. The block adds a valid/ready handshake, an optional 2-entry skid buffer, stall, flush-to-NOP and a downstream starvation counter. One instance sits between each pair of adjacent pipeline stages.

Parameters:
FIELD_W, 32, width of one payload field
NUM_FIELDS, 4, number of packed fields; payload width PW = FIELD_W*NUM_FIELDS
SKID, 1, 1 = registered in_ready with a 2-entry skid buffer; 0 = single entry with combinational ready pass-through
CNT_W, 16, width of bubble_cnt

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall  in  1  freeze the stage (hazard unit)
flush  in  1  discard contents and become a NOP (branch or jump kill)
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat
in_data  in  PW  upstream payload; field k = in_data[k*FIELD_W +: FIELD_W]
out_valid  out  1  stage holds a valid beat
out_ready  in  1  downstream accepts
out_data  out  PW  payload of the main entry
bubble_cnt  out  CNT_W  saturating count of cycles with out_ready=1 and out_valid=0

Behaviour:
- Interface fixed: one clock, clk; reset is synchronous and active-high, named reset.
- Fire rules:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Neither fire can occur while stall or flush is high.
- Storage and state:
  - Entries: main (drives out_data) and skid (present only when SKID=1).
  - State: EMPTY, FULL, or SKID (both entries held).
- Outputs:
  - out_valid = (state != EMPTY) & ~stall & ~flush.
  - out_data always shows main, even during stall.
  - in_ready:
    - SKID=1: (state != SKID) & ~stall & ~flush, built from registered state only.
    - SKID=0: (state == EMPTY | out_ready) & ~stall & ~flush.
- Transitions (only when not reset, not flush, not stall):
  - EMPTY: in_fire -> FULL, main <= in_data.
  - FULL: in_fire & out_fire -> FULL, main <= in_data.
  - FULL: in_fire only -> SKID, skid <= in_data (SKID=1 only).
  - FULL: out_fire only -> EMPTY, main <= 0.
  - SKID: out_fire -> FULL, main <= skid, skid <= 0.
  - SKID: no fire -> hold.
- Stall: state and both entries hold; bubble_cnt does not increment.
- Flush:
  - Next cycle state = EMPTY, main and skid = 0 (all-zero IR is sll $0,$0,0, a NOP).
  - Flush has priority over stall and over any same-cycle upstream beat; that beat is not accepted (in_ready=0).
- Reset:
  - Same effect as flush, plus bubble_cnt <= 0.
  - Reset mid-operation discards all held beats.
  - After reset: out_valid=0, out_data=0, in_ready=1, bubble_cnt=0.
- Latency: 1 cycle from in_fire to out_valid; throughput 1 beat per cycle under continuous out_ready.
- bubble_cnt: increments by 1 when out_ready & ~out_valid & ~stall; saturates at all-ones and never wraps.
- Ordering: beats leave strictly in arrival order; no beat is duplicated or dropped except by flush or reset.

Decomposition:
- Shared package/header: state encodings (ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2) and NOP_IR=32'h0, defined alongside the existing opcode constants.
- One natural sub-module: sat_counter (parametrised width, inc, clr), used for bubble_cnt.
- Field pack/unpack is done with part-selects at the instantiation site; no sub-module for it.

Test Plan:
1. Reset, then single beat in_data={32'h00400004, 32'h8C0A0004, …} with out_ready=1 -> out_valid one cycle later with identical out_data; in_ready stays 1 throughout.
2. SKID=1, out_ready=0, three consecutive beats A, B, C -> A and B accepted; in_ready=0 from the cycle after B; C held off. Raise out_ready -> A, B, C emerge in order on consecutive cycles.
3. State FULL with A, stall=1 for 3 cycles while in_valid=1 and out_ready=1 -> out_valid=0, out_data=A, no fires, bubble_cnt unchanged; after release A exits then the new beat follows.
4. State SKID, flush=1 coinciding with in_valid=1 and stall=1 -> next cycle out_data=0, out_valid=0, in_ready=1; neither the held beats nor the incoming beat ever appear.
5. CNT_W=4, out_ready=1, in_valid=0 for 20 cycles -> bubble_cnt reaches 15 and stays at 15; reset -> 0.
6. SKID=0, continuous in_valid and out_ready for 8 beats -> 8 beats out on 8 consecutive cycles; in_ready follows out_ready combinationally when FULL.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: stage occupancy
// encoding, the NOP instruction word and the primary opcode constants.
package pipe_stage_reg_pkg;

  // Occupancy of a stage register: nothing, main entry only, main + skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // All-zero IR decodes as sll $0,$0,0, so a zeroed payload is a bubble.
  localparam logic [31:0] NOP_IR = 32'h0000_0000;

  // Primary opcodes (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Extract the primary opcode from an instruction word.
  function automatic logic [5:0] opcode_of(input logic [31:0] ir);
    return ir[31:26];
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise step unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, optional 2-entry
// skid buffer, stall, flush-to-NOP and a downstream starvation counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned FIELD_W    = 32,
  parameter int unsigned NUM_FIELDS = 4,
  parameter int unsigned SKID       = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FIELD_W*NUM_FIELDS-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FIELD_W*NUM_FIELDS-1:0] out_data,
  output logic [CNT_W-1:0]              bubble_cnt
);

  localparam int unsigned PW = FIELD_W * NUM_FIELDS;

  state_e        state_q;
  state_e        state_d;
  logic [PW-1:0] main_q;
  logic [PW-1:0] main_d;
  logic [PW-1:0] skid_q;
  logic [PW-1:0] skid_d;

  logic live;
  logic in_fire;
  logic out_fire;
  logic bubble_inc;

  // Stall and flush both block every handshake on this cycle.
  assign live     = ~stall & ~flush;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Output decode: valid/ready derived from occupancy and the live gate.
  always_comb begin
    out_valid = (state_q != ST_EMPTY) & live;
    if (SKID != 0) begin
      // Ready depends only on registered state, breaking the ready path.
      in_ready = (state_q != ST_SKID) & live;
    end else begin
      in_ready = ((state_q == ST_EMPTY) | out_ready) & live;
    end
  end

  // Main entry is always visible, including while stalled.
  assign out_data = main_q;

  // Next-state and entry update; flush zeroes both entries to NOPs.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else if (!stall) begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_FULL;
            main_d  = in_data;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire && (SKID != 0)) begin
            state_d = ST_SKID;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            main_d  = '0;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            state_d = ST_FULL;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // State register with synchronous reset to empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Main payload register; reset leaves a NOP in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
    end else begin
      main_q <= main_d;
    end
  end

  if (SKID != 0) begin : g_skid
    // Skid payload register, only built when the skid buffer is enabled.
    always_ff @(posedge clk) begin
      if (reset) begin
        skid_q <= '0;
      end else begin
        skid_q <= skid_d;
      end
    end
  end else begin : g_no_skid
    assign skid_q = '0;
  end

  // Downstream asked for data but this stage had none, and was not frozen.
  assign bubble_inc = out_ready & ~out_valid & ~stall;

  sat_counter #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .clr_i(reset),
    .inc_i(bubble_inc),
    .cnt_o(bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid-buffered instance (CNT_W=4) and a
// pass-through instance (SKID=0) driven by the same stimulus.
module tb_pipe_stage_reg;

  localparam int FW = 32;
  localparam int NF = 4;
  localparam int PW = FW * NF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, stall, flush, in_valid, out_ready;
  logic [PW-1:0] in_data;

  logic          ir_s, ov_s, ir_n, ov_n;
  logic [PW-1:0] od_s, od_n;
  logic [3:0]    bc_s;
  logic [15:0]   bc_n;

  pipe_stage_reg #(
    .FIELD_W(FW), .NUM_FIELDS(NF), .SKID(1), .CNT_W(4)
  ) u_s (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_s), .in_data(in_data),
    .out_valid(ov_s), .out_ready(out_ready), .out_data(od_s),
    .bubble_cnt(bc_s)
  );

  pipe_stage_reg #(
    .FIELD_W(FW), .NUM_FIELDS(NF), .SKID(0), .CNT_W(16)
  ) u_n (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_n), .in_data(in_data),
    .out_valid(ov_n), .out_ready(out_ready), .out_data(od_n),
    .bubble_cnt(bc_n)
  );

  int errors = 0;
  int checks = 0;
  bit model_on = 1'b0;

  // Reference model: each stage is a FIFO of capacity 2 (skid) or 1.
  logic [PW-1:0] mdata [2][2];
  int mcount [2] = '{0, 0};
  int mbub   [2] = '{0, 0};
  int cmax   [2] = '{15, 65535};

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic m_ov(input int d);
    return (mcount[d] > 0) && !stall && !flush;
  endfunction

  function automatic logic m_ir(input int d);
    if (d == 0) return (mcount[d] < 2) && !stall && !flush;
    return ((mcount[d] == 0) || out_ready) && !stall && !flush;
  endfunction

  function automatic logic [PW-1:0] m_od(input int d);
    return (mcount[d] > 0) ? mdata[d][0] : '0;
  endfunction

  task automatic model_check();
    if (!model_on) return;
    chk("s.out_valid",  PW'(ov_s), PW'(m_ov(0)));
    chk("s.in_ready",   PW'(ir_s), PW'(m_ir(0)));
    chk("s.out_data",   od_s,      m_od(0));
    chk("s.bubble_cnt", PW'(bc_s), PW'(mbub[0]));
    chk("n.out_valid",  PW'(ov_n), PW'(m_ov(1)));
    chk("n.in_ready",   PW'(ir_n), PW'(m_ir(1)));
    chk("n.out_data",   od_n,      m_od(1));
    chk("n.bubble_cnt", PW'(bc_n), PW'(mbub[1]));
  endtask

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      logic ov;
      logic ir;
      ov = m_ov(d);
      ir = m_ir(d);
      if (reset) begin
        mcount[d] = 0;
        mbub[d]   = 0;
      end else begin
        if (out_ready && !ov && !stall && (mbub[d] < cmax[d])) mbub[d]++;
        if (flush) begin
          mcount[d] = 0;
        end else if (!stall) begin
          if (ov && out_ready) begin
            mdata[d][0] = mdata[d][1];
            mcount[d]--;
          end
          if (in_valid && ir) begin
            mdata[d][mcount[d]] = in_data;
            mcount[d]++;
          end
        end
      end
    end
  endtask

  // Called at negedge+1 with inputs settled; advances to the next negedge.
  task automatic cycle_end();
    model_check();
    model_update();
    @(negedge clk);
  endtask

  task automatic drv(input logic iv, input logic [PW-1:0] d, input logic orr,
                     input logic st, input logic fl);
    reset     = 1'b0;
    in_valid  = iv;
    in_data   = d;
    out_ready = orr;
    stall     = st;
    flush     = fl;
  endtask

  typedef struct {
    logic          iv;
    logic [PW-1:0] din;
    logic          orr;
    logic          st;
    logic          fl;
    logic          e_ov;
    logic [PW-1:0] e_od;
    logic          e_ir;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [PW-1:0] din, input logic orr,
                              input logic st, input logic fl, input logic e_ov,
                              input logic [PW-1:0] e_od, input logic e_ir);
    vec_t v;
    v.iv = iv; v.din = din; v.orr = orr; v.st = st; v.fl = fl;
    v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir;
    return v;
  endfunction

  function automatic logic [PW-1:0] beat(input int k);
    return {32'h0040_0000 + 32'(4 * k), 32'h2008_0000 + 32'(k), 32'(k * 3), 32'(~k)};
  endfunction

  localparam logic [PW-1:0] A = {32'h0040_0004, 32'h8C0A_0004, 32'h0000_0011, 32'h0000_0022};
  localparam logic [PW-1:0] B = {32'h0040_0008, 32'h8C0B_0008, 32'h0000_0033, 32'h0000_0044};
  localparam logic [PW-1:0] C = {32'h0040_000C, 32'h014B_6020, 32'h0000_0055, 32'h0000_0066};
  localparam logic [PW-1:0] D = {32'h0040_0010, 32'h0810_0000, 32'h0000_0077, 32'h0000_0088};
  localparam logic [PW-1:0] Z = '0;

  vec_t tbl [21];

  initial begin
    // Single beat, then skid fill/drain, stall, and flush-in-SKID; checked on u_s.
    tbl[0]  = mk(1, A, 1, 0, 0, 0, Z, 1);
    tbl[1]  = mk(0, Z, 1, 0, 0, 1, A, 1);
    tbl[2]  = mk(0, Z, 1, 0, 0, 0, Z, 1);
    tbl[3]  = mk(1, A, 0, 0, 0, 0, Z, 1);
    tbl[4]  = mk(1, B, 0, 0, 0, 1, A, 1);
    tbl[5]  = mk(1, C, 0, 0, 0, 1, A, 0);
    tbl[6]  = mk(1, C, 1, 0, 0, 1, A, 0);
    tbl[7]  = mk(1, C, 1, 0, 0, 1, B, 1);
    tbl[8]  = mk(0, Z, 1, 0, 0, 1, C, 1);
    tbl[9]  = mk(0, Z, 1, 0, 0, 0, Z, 1);
    tbl[10] = mk(1, A, 0, 0, 0, 0, Z, 1);
    tbl[11] = mk(1, D, 1, 1, 0, 0, A, 0);
    tbl[12] = mk(1, D, 1, 1, 0, 0, A, 0);
    tbl[13] = mk(1, D, 1, 1, 0, 0, A, 0);
    tbl[14] = mk(1, D, 1, 0, 0, 1, A, 1);
    tbl[15] = mk(0, Z, 1, 0, 0, 1, D, 1);
    tbl[16] = mk(1, A, 0, 0, 0, 0, Z, 1);
    tbl[17] = mk(1, B, 0, 0, 0, 1, A, 1);
    tbl[18] = mk(1, C, 0, 1, 1, 0, A, 0);
    tbl[19] = mk(0, Z, 1, 0, 0, 0, Z, 1);
    tbl[20] = mk(0, Z, 1, 0, 0, 0, Z, 1);

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(negedge clk); #1;
    cycle_end();
    model_on = 1'b1;
    reset = 1'b1;
    #1; cycle_end();

    // Post-reset state.
    drv(0, Z, 0, 0, 0);
    #1;
    chk("rst.s.out_valid",  PW'(ov_s), Z);
    chk("rst.s.out_data",   od_s,      Z);
    chk("rst.s.in_ready",   PW'(ir_s), PW'(1));
    chk("rst.s.bubble_cnt", PW'(bc_s), Z);
    chk("rst.n.in_ready",   PW'(ir_n), PW'(1));
    chk("rst.n.bubble_cnt", PW'(bc_n), Z);
    cycle_end();

    for (int i = 0; i < 21; i++) begin
      drv(tbl[i].iv, tbl[i].din, tbl[i].orr, tbl[i].st, tbl[i].fl);
      #1;
      chk($sformatf("tbl[%0d].out_valid", i), PW'(ov_s), PW'(tbl[i].e_ov));
      chk($sformatf("tbl[%0d].out_data", i),  od_s,      tbl[i].e_od);
      chk($sformatf("tbl[%0d].in_ready", i),  PW'(ir_s), PW'(tbl[i].e_ir));
      cycle_end();
    end

    // Bubble counter saturation on the 4-bit instance, then reset clears it.
    drv(0, Z, 1, 0, 0);
    reset = 1'b1;
    #1; cycle_end();
    reset = 1'b0;
    repeat (20) begin
      #1; cycle_end();
    end
    #1;
    chk("sat.s.bubble_cnt", PW'(bc_s), PW'(15));
    chk("sat.n.bubble_cnt", PW'(bc_n), PW'(20));
    cycle_end();
    #1;
    chk("sat.s.hold", PW'(bc_s), PW'(15));
    reset = 1'b1;
    cycle_end();
    reset = 1'b0;
    #1;
    chk("sat.s.cleared", PW'(bc_s), Z);
    chk("sat.n.cleared", PW'(bc_n), Z);
    cycle_end();

    // Pass-through stage streams 8 beats back-to-back.
    drv(0, Z, 1, 0, 0);
    reset = 1'b1;
    #1; cycle_end();
    for (int k = 0; k <= 8; k++) begin
      drv(k < 8, beat(k), 1, 0, 0);
      #1;
      if (k > 0) begin
        chk($sformatf("stream[%0d].out_valid", k), PW'(ov_n), PW'(1));
        chk($sformatf("stream[%0d].out_data", k),  od_n,      beat(k - 1));
      end
      chk($sformatf("stream[%0d].in_ready", k), PW'(ir_n), PW'(1));
      cycle_end();
    end

    // When full, the pass-through ready tracks out_ready within the cycle.
    drv(1, D, 0, 0, 0);
    #1; cycle_end();
    drv(0, Z, 0, 0, 0);
    #1;
    chk("comb.n.ready_low", PW'(ir_n), Z);
    out_ready = 1'b1;
    #1;
    chk("comb.n.ready_high", PW'(ir_n), PW'(1));
    chk("comb.n.out_data",   od_n,      D);
    cycle_end();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      #1;
      cycle_end();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
